display_arbiter: RTL and testbench

DISPLAY_ARBITER -- requirements
Module: display_arbiter

---
 rtl/display_pkg.sv | 25 ++
 rtl/rr_pick4.sv | 32 +++
 rtl/display_arbiter.sv | 122 ++++++++++++
 tb/tb_display_arbiter.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
`default_nettype none
// display_pkg: shared source count, data width, FSM encoding and
// one-hot helper used by the display arbiter.
package display_pkg;

  localparam int NUM_SRC = 4;
  localparam int DATA_W  = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SHOW = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  function automatic logic [1:0] onehot_to_idx(input logic [NUM_SRC-1:0] oh);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (oh[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick4.sv
`default_nettype none
// rr_pick4: combinational round-robin search over four requests,
// starting at ptr and wrapping; returns a one-hot winner and a valid flag.
module rr_pick4
  import display_pkg::*;
(
  input  logic [NUM_SRC-1:0] req,
  input  logic [1:0]         ptr,
  output logic [NUM_SRC-1:0] winner,
  output logic               valid
);

  always_comb begin : pick
    logic [1:0] idx;
    logic       found;
    winner = '0;
    found  = 1'b0;
    idx    = ptr;
    for (int k = 0; k < NUM_SRC; k++) begin
      // 2-bit addition wraps naturally modulo 4
      idx = ptr + 2'(k);
      if (!found && req[idx]) begin
        winner[idx] = 1'b1;
        found       = 1'b1;
      end
    end
  end

  assign valid = |req;

endmodule
`default_nettype wire

// File: rtl/display_arbiter.sv
`default_nettype none
// display_arbiter: round-robin time-sharing of one 4-digit display among
// four sources, with dwell, inter-grant blanking gap and a hold (lock) input.
module display_arbiter
  import display_pkg::*;
#(
  parameter int DWELL_CYCLES = 25_000_000,
  parameter int GAP_CYCLES   = 1_000_000,
  parameter int CNT_W        = 26
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_SRC-1:0]        req,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  input  logic                      lock,
  output logic [DATA_W-1:0]         disp_data,
  output logic                      disp_blank,
  output logic [NUM_SRC-1:0]        grant,
  output logic [NUM_SRC-1:0]        done
);

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);

  state_t             state;
  logic [1:0]         ptr;
  logic [CNT_W-1:0]   cnt;
  logic [DATA_W-1:0]  slice [NUM_SRC];
  logic [NUM_SRC-1:0] win;
  logic               win_valid;
  logic [1:0]         win_idx;
  logic [1:0]         gnt_idx;

  generate
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_slice
      assign slice[i] = src_data[DATA_W*i +: DATA_W];
    end
  endgenerate

  rr_pick4 u_pick (
    .req    (req),
    .ptr    (ptr),
    .winner (win),
    .valid  (win_valid)
  );

  assign win_idx = onehot_to_idx(win);
  assign gnt_idx = onehot_to_idx(grant);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      ptr        <= 2'd0;
      cnt        <= '0;
      grant      <= '0;
      done       <= '0;
      disp_data  <= '0;
      disp_blank <= 1'b1;
    end else begin
      done <= '0;
      case (state)
        ST_IDLE: begin
          if (win_valid) begin
            state      <= ST_SHOW;
            grant      <= win;
            cnt        <= '0;
            disp_blank <= 1'b0;
            disp_data  <= slice[win_idx];
          end
        end

        ST_SHOW: begin
          disp_data <= slice[gnt_idx];
          // A dropped request takes priority over dwell expiry: no done pulse
          if (!req[gnt_idx]) begin
            state      <= ST_GAP;
            grant      <= '0;
            disp_blank <= 1'b1;
            cnt        <= '0;
            ptr        <= gnt_idx + 2'd1;
          end else if (cnt == DWELL_LAST) begin
            if (!lock) begin
              done       <= grant;
              state      <= ST_GAP;
              grant      <= '0;
              disp_blank <= 1'b1;
              cnt        <= '0;
              ptr        <= gnt_idx + 2'd1;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        ST_GAP: begin
          if (cnt == GAP_LAST) begin
            cnt <= '0;
            if (win_valid) begin
              state      <= ST_SHOW;
              grant      <= win;
              disp_blank <= 1'b0;
              disp_data  <= slice[win_idx];
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        default: begin
          state      <= ST_IDLE;
          grant      <= '0;
          disp_blank <= 1'b1;
          cnt        <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_display_arbiter.sv
`default_nettype none
// tb_display_arbiter: directed self-checking bench, DWELL_CYCLES=8, GAP_CYCLES=2.
module tb_display_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [63:0] src_data;
  logic        lock;
  logic [15:0] disp_data;
  logic        disp_blank;
  logic [3:0]  grant;
  logic [3:0]  done;

  int checks   = 0;
  int failures = 0;

  display_arbiter #(
    .DWELL_CYCLES (8),
    .GAP_CYCLES   (2),
    .CNT_W        (26)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .src_data   (src_data),
    .lock       (lock),
    .disp_data  (disp_data),
    .disp_blank (disp_blank),
    .grant      (grant),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        failures++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] order [5];
    order[0] = 4'b0001; order[1] = 4'b0010; order[2] = 4'b0100;
    order[3] = 4'b1000; order[4] = 4'b0001;

    rst_n = 1'b0; req = 4'b0000; src_data = '0; lock = 1'b0;
    step(2);
    chk("reset_grant", 32'(grant), 32'h0);
    chk("reset_blank", 32'(disp_blank), 32'h1);
    chk("reset_data",  32'(disp_data), 32'h0);
    chk("reset_done",  32'(done), 32'h0);
    rst_n = 1'b1;
    step(1);
    chk("idle_no_req_grant", 32'(grant), 32'h0);

    // Single requester: grant, dwell of 8, two blank cycles, re-grant
    req = 4'b0001; src_data[15:0] = 16'h1234;
    src_data[31:16] = 16'hABCD;
    step(1);
    chk("t1_grant", 32'(grant), 32'h1);
    chk("t1_blank", 32'(disp_blank), 32'h0);
    chk("t1_data",  32'(disp_data), 32'h1234);
    step(7);
    chk("t1_last_show_grant", 32'(grant), 32'h1);
    chk("t1_last_show_done",  32'(done), 32'h0);
    step(1);
    chk("t1_done",       32'(done), 32'h1);
    chk("t1_gap1_grant", 32'(grant), 32'h0);
    chk("t1_gap1_blank", 32'(disp_blank), 32'h1);
    chk("t1_gap1_data",  32'(disp_data), 32'h1234);
    step(1);
    chk("t1_gap2_done",  32'(done), 32'h0);
    chk("t1_gap2_blank", 32'(disp_blank), 32'h1);
    step(1);
    chk("t1_regrant", 32'(grant), 32'h1);

    // All four requesting: strict rotation
    req = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      chk("t2_grant", 32'(grant), 32'(order[k]));
      step(8);
      chk("t2_done", 32'(done), 32'(order[k]));
      chk("t2_gap_grant", 32'(grant), 32'h0);
      step(2);
    end
    chk("t2_grant_wrap", 32'(grant), 32'(order[4]));

    // Lock raised in third show cycle for ten cycles
    step(2);
    lock = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step(1);
      chk("t3_locked_grant", 32'(grant), 32'h1);
      chk("t3_locked_done",  32'(done), 32'h0);
    end
    lock = 1'b0;
    step(1);
    chk("t3_done_after_unlock", 32'(done), 32'h1);
    step(2);
    chk("t3_next_grant", 32'(grant), 32'h2);

    // Source 2 drops its request in its fourth show cycle
    step(8);
    chk("t4_done1", 32'(done), 32'h2);
    step(2);
    chk("t4_grant2", 32'(grant), 32'h4);
    step(3);
    req = 4'b1011;
    step(1);
    chk("t4_drop_grant", 32'(grant), 32'h0);
    chk("t4_drop_blank", 32'(disp_blank), 32'h1);
    chk("t4_drop_done",  32'(done), 32'h0);
    step(1);
    chk("t4_gap2_done", 32'(done), 32'h0);
    step(1);
    chk("t4_next_from3", 32'(grant), 32'h8);

    // Drop source 3 to reach source 1, then change its data while shown
    req = 4'b0010;
    step(1);
    chk("t6_drop_done", 32'(done), 32'h0);
    step(2);
    chk("t6_grant1", 32'(grant), 32'h2);
    chk("t6_data_abcd", 32'(disp_data), 32'hABCD);
    step(1);
    src_data[31:16] = 16'h0F0F;
    chk("t6_data_before", 32'(disp_data), 32'hABCD);
    step(1);
    chk("t6_data_after", 32'(disp_data), 32'h0F0F);
    step(6);
    chk("t6_done1", 32'(done), 32'h2);
    step(2);
    chk("t6_sole_regrant", 32'(grant), 32'h2);

    // Asynchronous reset mid-show, then arbitration restarts from ptr 0
    step(2);
    rst_n = 1'b0;
    #1;
    chk("t5_async_grant", 32'(grant), 32'h0);
    chk("t5_async_blank", 32'(disp_blank), 32'h1);
    chk("t5_async_data",  32'(disp_data), 32'h0);
    req = 4'b0110;
    step(1);
    chk("t5_held_grant", 32'(grant), 32'h0);
    rst_n = 1'b1;
    step(1);
    chk("t5_after_grant", 32'(grant), 32'h2);
    chk("t5_after_blank", 32'(disp_blank), 32'h0);
    chk("t5_after_data",  32'(disp_data), 32'h0F0F);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
